// File: rtl/sequential_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start/ready handshake, dividend and
// divisor in; quotient, remainder, div_by_zero out (registered).
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;

  // A stays below M, so the shifted A is below 2M and fits WIDTH+1 bits.
  assign a_sh  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign q_sh  = q_q << 1;
  assign trial = a_sh - {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d     = dividend;
          m_d     = divisor;
          a_d     = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (trial[WIDTH]) begin
          a_d = a_sh;
          q_d = q_sh;
        end else begin
          a_d = trial;
          q_d = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          quot_d  = q_d;
          rem_d   = a_d[WIDTH-1:0];
          dbz_d   = (m_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign ready       = (state_q == S_IDLE);

endmodule

// File: tb/tb_sequential_divider.sv
// Directed testbench for sequential_divider (WIDTH=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sequential_divider #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .ready(ready)
  );

  // Stimulus only: issue one op, wait for ready, report busy cycles.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int busy, output bit tmo);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 4'hx; divisor = 4'hx;
    busy = 0;
    while (!ready && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    tmo = !ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if (ready !== 1'b1 || quotient !== 4'd0 || remainder !== 4'd0 ||
        div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b q=%0d r=%0d dbz=%b, want 1 0 0 0",
               ready, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_start_same_edge: rdy=%b, want 1", ready);
    end
  endtask

  task automatic test_basic();
    int busy; bit tmo;
    run_op(4'd13, 4'd3, busy, tmo);
    checks++;
    if (tmo || busy != 4) begin
      errors++;
      $display("FAIL basic_latency: busy=%0d tmo=%b, want 4 0", busy, tmo);
    end
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_13_3: q=%0d r=%0d dbz=%b, want 4 1 0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va [5] = '{4'd15, 4'd5, 4'd0, 4'd15, 4'd14};
    logic [3:0] vb [5] = '{4'd1, 4'd7, 4'd9, 4'd15, 4'd4};
    logic [3:0] vq [5] = '{4'd15, 4'd0, 4'd0, 4'd1, 4'd3};
    logic [3:0] vr [5] = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd2};
    int busy; bit tmo;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], busy, tmo);
      checks++;
      if (tmo || quotient !== vq[i] || remainder !== vr[i] ||
          div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL vec_%0d_%0d: q=%0d r=%0d dbz=%b tmo=%b, want %0d %0d 0",
                 va[i], vb[i], quotient, remainder, div_by_zero, tmo,
                 vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int busy; bit tmo;
    run_op(4'd9, 4'd0, busy, tmo);
    checks++;
    if (tmo || busy != 4 || quotient !== 4'd15 || remainder !== 4'd9 ||
        div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_9_0: q=%0d r=%0d dbz=%b busy=%0d, want 15 9 1 4",
               quotient, remainder, div_by_zero, busy);
    end
    run_op(4'd8, 4'd2, busy, tmo);
    checks++;
    if (tmo || quotient !== 4'd4 || remainder !== 4'd0 ||
        div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear_8_2: q=%0d r=%0d dbz=%b, want 4 0 0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_busy();
    int busy;
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd7; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    busy = 0;
    while (!ready && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    checks++;
    if (!ready || busy != 2 || quotient !== 4'd2 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL start_busy_12_5: q=%0d r=%0d rdy=%b busy=%0d, want 2 2 1 2",
               quotient, remainder, ready, busy);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || quotient !== 4'd2) begin
      errors++;
      $display("FAIL start_busy_no_queue: rdy=%b q=%0d, want 1 2",
               ready, quotient);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || quotient !== 4'd0 || remainder !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b q=%0d r=%0d, want 1 0 0",
               ready, quotient, remainder);
    end
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready !== 1'b1 || quotient !== 4'd0 || remainder !== 4'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_no_update: rdy=%b q=%0d r=%0d, want 1 0 0",
               ready, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int busy = 0;
    int cyc = 0;
    bit pending = 1'b0;
    bit done = 1'b0;
    logic [3:0] eq, er, hq, hr;
    logic       edbz;
    logic [7:0] kv;
    start = 1'b1;
    while (!done && cyc < 256 * 5 + 40) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        if (pending) begin
          checks++;
          if (quotient !== eq || remainder !== er || div_by_zero !== edbz ||
              busy != 4) begin
            errors++;
            $display("FAIL b2b_%0d_%0d: q=%0d r=%0d dbz=%b busy=%0d, want %0d %0d %b 4",
                     kv[7:4], kv[3:0], quotient, remainder, div_by_zero,
                     busy, eq, er, edbz);
          end
        end
        if (k < 256) begin
          kv = k[7:0];
          dividend = kv[7:4];
          divisor  = kv[3:0];
          if (kv[3:0] == 4'd0) begin
            eq = 4'hf; er = kv[7:4]; edbz = 1'b1;
          end else begin
            eq = kv[7:4] / kv[3:0]; er = kv[7:4] % kv[3:0]; edbz = 1'b0;
          end
          hq = quotient; hr = remainder;
          pending = 1'b1; busy = 0; k++;
        end else begin
          done = 1'b1;
        end
      end else begin
        busy++;
        checks++;
        if (quotient !== hq || remainder !== hr) begin
          errors++;
          $display("FAIL b2b_hold: q=%0d r=%0d, want %0d %0d",
                   quotient, remainder, hq, hr);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_timeout: ops=%0d, want 256", k);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
